// File: rtl/serial_tx_5.sv
// Purpose : 5-bit command word to framed serial line (start, 5 data LSB first, optional even parity, stop).
// Latency : start bit on the line one edge after accept; done pulses (7+PARITY_EN)*CLKS_PER_BIT cycles after accept.
// Backpr. : ready low for the whole frame; ctrl_send while busy is dropped, nothing is queued.
module serial_tx_5 #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic       clock,
    input  logic       ctrl_reset,
    input  logic [4:0] data_in,
    input  logic       ctrl_send,
    output logic       ready,
    output logic       busy,
    output logic       tx_out,
    output logic       done
);

    // Counter is at least one bit wide so CLKS_PER_BIT=1 still elaborates;
    // in that case it sits at zero and every cycle is a bit boundary.
    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LAST_IDX = 3'd4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [4:0]       shift_reg;
    logic             parity_bit;
    logic             bit_end;
    logic             accept;
    logic             data_bit_nxt;
    logic             tx_nxt;

    // A bit slot ends on the edge where the cycle counter reaches its last value.
    assign bit_end = (bit_cnt == CNT_LAST);
    assign accept  = (state == S_IDLE) && ctrl_send;

    // The handshake is a pure decode of the state so ready and busy can never disagree.
    assign ready = (state == S_IDLE);
    assign busy  = ~ready;

    // Frame sequencing: each non-idle state lasts exactly one bit slot, except DATA which lasts five.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ctrl_send) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (bit_idx == LAST_IDX)) begin
                    state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit timer: held at zero while idle, restarts at every slot boundary.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            bit_cnt <= '0;
        end else if ((state == S_IDLE) || bit_end) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Data bit index: cleared on accept, steps once per completed data slot.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            bit_idx <= '0;
        end else if (accept) begin
            bit_idx <= '0;
        end else if ((state == S_DATA) && bit_end) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // Word capture: data_in and its parity are only looked at on the accept edge,
    // then the word shifts right so the bit on the line is always shift_reg[0].
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else if (accept) begin
            shift_reg  <= data_in;
            parity_bit <= ^data_in;
        end else if ((state == S_DATA) && bit_end) begin
            shift_reg  <= {1'b0, shift_reg[4:1]};
        end
    end

    // Line level for the next cycle. When a data slot ends the shift has not
    // happened yet, so the upcoming bit is shift_reg[1] rather than [0].
    always_comb begin
        data_bit_nxt = shift_reg[0];
        if ((state == S_DATA) && bit_end) begin
            data_bit_nxt = shift_reg[1];
        end
        tx_nxt = 1'b1;
        case (state_nxt)
            S_IDLE:   tx_nxt = 1'b1;
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = data_bit_nxt;
            S_PARITY: tx_nxt = parity_bit;
            S_STOP:   tx_nxt = 1'b1;
            default:  tx_nxt = 1'b1;
        endcase
    end

    // Registered line driver keeps tx_out glitch-free and aligned with the state register.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            tx_out <= 1'b1;
        end else begin
            tx_out <= tx_nxt;
        end
    end

    // Completion pulse: only the edge that closes the stop slot raises it, for one cycle.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            done <= 1'b0;
        end else begin
            done <= (state == S_STOP) && bit_end;
        end
    end

endmodule

// File: tb/tb_serial_tx_5.sv
// Purpose : randomized and directed stimulus for two serial_tx_5 configurations against a frame-level model.
// Latency : model predicts the line one cycle at a time, compared on the falling edge.
// Backpr. : model accepts a word only in a cycle it predicts ready high.
module tb_serial_tx_5;

    logic       clock = 1'b0;
    logic       ctrl_reset;
    logic [4:0] data_in;
    logic       ctrl_send;

    logic ready_a, busy_a, tx_a, done_a;
    logic ready_b, busy_b, tx_b, done_b;

    always #5 clock = ~clock;

    serial_tx_5 #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .data_in    (data_in),
        .ctrl_send  (ctrl_send),
        .ready      (ready_a),
        .busy       (busy_a),
        .tx_out     (tx_a),
        .done       (done_a)
    );

    serial_tx_5 #(.CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .data_in    (data_in),
        .ctrl_send  (ctrl_send),
        .ready      (ready_b),
        .busy       (busy_b),
        .tx_out     (tx_b),
        .done       (done_b)
    );

    // Expected per-cycle observation packed as {tx, ready, done}.
    localparam logic [2:0] IDLE_OBS = 3'b110;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [2:0] qa[$];
    logic [2:0] qb[$];
    logic [2:0] cur_a = IDLE_OBS;
    logic [2:0] cur_b = IDLE_OBS;
    int         exp_done_a = 0;
    int         exp_done_b = 0;
    int         obs_done_a = 0;
    int         obs_done_b = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Builds the whole expected line for one word: each serial bit repeated cpb
    // times, then the single idle cycle in which done is high and ready returns.
    task automatic push_frame(input bit to_b, input logic [4:0] w, input int cpb, input bit pen);
        logic bits[$];
        int   ones;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < 5; i++) begin
            bits.push_back(w[i]);
            if (w[i]) ones++;
        end
        if (pen) bits.push_back((ones % 2) == 1);
        bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int r = 0; r < cpb; r++) begin
                if (to_b) qb.push_back({bits[k], 2'b00});
                else      qa.push_back({bits[k], 2'b00});
            end
        end
        if (to_b) qb.push_back(3'b111);
        else      qa.push_back(3'b111);
    endtask

    task automatic model_step(input logic snd, input logic [4:0] d);
        if (cur_a[1] && snd) push_frame(1'b0, d, 4, 1'b1);
        if (cur_b[1] && snd) push_frame(1'b1, d, 1, 1'b0);
        cur_a = (qa.size() > 0) ? qa.pop_front() : IDLE_OBS;
        cur_b = (qb.size() > 0) ? qb.pop_front() : IDLE_OBS;
        if (cur_a[0]) exp_done_a++;
        if (cur_b[0]) exp_done_b++;
    endtask

    task automatic check_outputs();
        chk("a_tx",    32'(tx_a),    32'(cur_a[2]));
        chk("a_ready", 32'(ready_a), 32'(cur_a[1]));
        chk("a_busy",  32'(busy_a),  32'(!cur_a[1]));
        chk("a_done",  32'(done_a),  32'(cur_a[0]));
        chk("b_tx",    32'(tx_b),    32'(cur_b[2]));
        chk("b_ready", 32'(ready_b), 32'(cur_b[1]));
        chk("b_busy",  32'(busy_b),  32'(!cur_b[1]));
        chk("b_done",  32'(done_b),  32'(cur_b[0]));
        if (done_a) obs_done_a++;
        if (done_b) obs_done_b++;
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge,
    // compare at the next falling edge.
    task automatic cycle(input logic snd, input logic [4:0] d);
        ctrl_send = snd;
        data_in   = d;
        @(posedge clock);
        model_step(snd, d);
        @(negedge clock);
        check_outputs();
    endtask

    // Reset pulse from a falling edge: outputs must return to idle before any clock edge.
    task automatic do_reset();
        ctrl_reset = 1'b1;
        ctrl_send  = 1'b0;
        #1;
        qa.delete();
        qb.delete();
        cur_a = IDLE_OBS;
        cur_b = IDLE_OBS;
        check_outputs();
        @(posedge clock);
        @(negedge clock);
        check_outputs();
        ctrl_reset = 1'b0;
    endtask

    initial begin
        ctrl_reset = 1'b1;
        ctrl_send  = 1'b0;
        data_in    = 5'd0;
        @(posedge clock);
        @(negedge clock);
        check_outputs();
        ctrl_reset = 1'b0;
        repeat (3) cycle(1'b0, 5'd0);

        // Reference word with odd weight: parity slot high.
        cycle(1'b1, 5'b10110);
        repeat (39) cycle(1'b0, 5'($urandom));

        // All-zero word: parity slot low.
        cycle(1'b1, 5'b00000);
        repeat (40) cycle(1'b0, 5'($urandom));

        // Send request mid-frame must be ignored by the long-bit configuration.
        cycle(1'b1, 5'b01101);
        repeat (9) cycle(1'b0, 5'($urandom));
        cycle(1'b1, 5'b11111);
        repeat (30) cycle(1'b0, 5'($urandom));

        // Send held high: back-to-back frames separated by a single idle cycle.
        for (int i = 0; i < 66; i++) begin
            cycle(1'b1, (i < 33) ? 5'b00001 : 5'b00010);
        end
        repeat (40) cycle(1'b0, 5'($urandom));

        // Reset during data bit 2 (a zero on the line), then a clean frame.
        cycle(1'b1, 5'b11011);
        repeat (13) cycle(1'b0, 5'($urandom));
        do_reset();
        cycle(1'b1, 5'b01010);
        repeat (40) cycle(1'b0, 5'($urandom));

        // All-ones word, short configuration shows 0 then six ones.
        cycle(1'b1, 5'b11111);
        repeat (40) cycle(1'b0, 5'($urandom));

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle($urandom_range(0, 3) == 0, 5'($urandom));
        end
        repeat (40) cycle(1'b0, 5'($urandom));

        chk("a_done_count", 32'(obs_done_a), 32'(exp_done_a));
        chk("b_done_count", 32'(obs_done_b), 32'(exp_done_b));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_tx_5.md
Name: serial_tx_5

Overview:
- Parallel-to-serial transmitter for 5-bit command words (motor/pen opcodes) leaving the processor toward the drawing-robot controller.
- Accepts one 5-bit word through a ready/send handshake.
- Emits one framed serial bit stream on a single registered line: start bit, 5 data bits LSB first, optional even parity bit, stop bit.
- It is the sending end of the 5-bit capture path: it drives words out, where the capture registers latch words in.

Parameters:
- CLKS_PER_BIT, 4: clock cycles each serial bit is held; legal range is 1 or greater.
- PARITY_EN, 1: 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- ctrl_reset  input  1  asynchronous, active-high reset.
- data_in  input  5  word to transmit; sampled only on the accept edge.
- ctrl_send  input  1  request to transmit; accepted on an edge where ready=1.
- ready  output  1  high when a new word can be accepted.
- busy  output  1  high while a frame is in progress; always the inverse of ready.
- tx_out  output  1  serial line; idle high; registered, glitch-free.
- done  output  1  one-cycle pulse marking frame completion.

Behaviour:
- Reset (asynchronous, immediate):
  - tx_out=1, ready=1, busy=0, done=0.
  - State=IDLE; bit counter and bit index cleared; shift register cleared.
- States: IDLE, START, DATA, PARITY, STOP.
  - PARITY is skipped when PARITY_EN=0.
- IDLE:
  - tx_out=1.
  - On a rising edge with ctrl_send=1: latch data_in into the shift register, latch parity = XOR of the 5 bits, go to START.
  - After that edge: ready=0, busy=1, tx_out=0. Latency from accept edge to start bit on the line is one edge.
- Bit timing:
  - Every bit is held for exactly CLKS_PER_BIT cycles, using a cycle counter 0..CLKS_PER_BIT-1.
  - The state or bit advances on the edge where the counter equals CLKS_PER_BIT-1.
- DATA: bits sent LSB first, index 0..4; after bit 4, go to PARITY, or to STOP when PARITY_EN=0.
- PARITY: tx_out = latched even parity, so the total number of ones in data plus parity is even.
- STOP: tx_out=1 for CLKS_PER_BIT cycles. Then go to IDLE, with ready=1, busy=0 and done=1 for exactly one cycle.
- Frame length:
  - (7+PARITY_EN)*CLKS_PER_BIT cycles from the accept edge to the done edge.
  - Defaults give 32 cycles.
- ctrl_send while busy: ignored, with no queueing. data_in changes mid-frame have no effect on the frame in progress.
- Back-to-back frames:
  - If ctrl_send=1 in the first cycle ready is back high, the word is accepted on the next edge.
  - The line then shows exactly one idle-high cycle after the stop bit before the next start bit.
  - done still pulses once for the previous frame.
- CLKS_PER_BIT=1: every bit lasts one cycle; the counter is degenerate but legal.
- Reset mid-frame:
  - tx_out returns to 1 immediately and the in-flight word is discarded.
  - No done pulse for the aborted frame.
  - The next accepted word transmits normally.
- done never asserts outside the single cycle following STOP completion.

Test Plan:
- Defaults, send 5'b10110 at edge T0:
  - tx_out in 4-cycle bit slots reads 0 (start), 0, 1, 1, 0, 1 (data), 1 (parity), 1 (stop).
  - done=1 for one cycle after edge T0+32; ready=0 from T0+1 through T0+32.
- Defaults, send 5'b00000: parity slot = 0; frame is 32 cycles; the only zeros on the line are the start, data and parity slots.
- Assert ctrl_send with 5'b11111 at T0+10 mid-frame: ignored; the line bit sequence is unchanged and only one done pulse occurs.
- Hold ctrl_send=1 continuously with data 5'b00001, then 5'b00010:
  - Two frames with one idle cycle between them.
  - Data slots read 1,0,0,0,0 then 0,1,0,0,0.
  - Two done pulses, 33 cycles apart.
- Pulse ctrl_reset during data bit 2:
  - tx_out=1 in the same cycle; ready=1; no done pulse.
  - A following send of 5'b01010 produces a correct full frame.
- PARITY_EN=0, CLKS_PER_BIT=1, send 5'b11111: tx_out = 0,1,1,1,1,1,1 over 7 cycles; done one cycle after edge T0+7.
